// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: receiver states, oversampling constants
// and line levels common to the transmitter and receiver.
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int OVS = 16;

    localparam logic [3:0] OS_V0 = 4'd7;
    localparam logic [3:0] OS_V1 = 4'd8;
    localparam logic [3:0] OS_V2 = 4'd9;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rs232_rx_if.sv
// Byte delivery channel of the RS232 receiver: valid/ready plus
// framing-error and overrun strobes.
interface rs232_rx_if;

    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_rdy;
    logic       rx_ferr;
    logic       rx_ovr;

    modport master (
        output rx_data, rx_vld, rx_ferr, rx_ovr,
        input  rx_rdy
    );

    modport slave (
        input  rx_data, rx_vld, rx_ferr, rx_ovr,
        output rx_rdy
    );

endinterface

// File: rtl/rs232_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks,
// restartable so the tick phase can be aligned to a frame.
module rs232_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (!reset || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // DIV==1 keeps the counter pinned at 0, so tick is high every cycle.
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/rs232_rx.sv
// RS232 receiver: 16x oversampling, 3-sample majority vote,
// valid/ready byte delivery with framing-error and overrun strobes.
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int baud = 9600,
    parameter int mhz  = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RS232_DCE_RXD,
    rs232_rx_if.master rx
);

    localparam int TICK_DIV = (mhz * 1_000_000) / (baud * 16);

    rx_state_t  r_state;
    rx_state_t  w_next;
    logic [1:0] r_sync;
    logic       r_s_d;
    logic [3:0] r_os;
    logic [2:0] r_idx;
    logic [7:0] r_sh;
    logic       r_v7;
    logic       r_v8;
    logic [7:0] r_data;
    logic       r_vld;
    logic       r_ferr;
    logic       r_ovr;

    logic w_s;
    logic w_tick;
    logic w_clr;
    logic w_mid;
    logic w_vote;
    logic w_dlv;
    logic w_ferr;

    assign w_s    = r_sync[1];
    assign w_mid  = w_tick && (r_os == OS_V2);
    assign w_vote = maj3(r_v7, r_v8, w_s);

    rs232_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_dlv  = 1'b0;
        w_ferr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_s == LINE_START && r_s_d == LINE_IDLE) begin
                    w_next = START;
                    w_clr  = 1'b1;
                end
            end
            START: begin
                if (w_mid) begin
                    w_next = w_vote ? DATA : IDLE;
                end
            end
            DATA: begin
                if (w_mid && r_idx == 3'd7) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (w_mid) begin
                    if (w_vote == LINE_IDLE) begin
                        w_dlv  = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_tick && w_s == LINE_IDLE && r_os == 4'(OVS - 1)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync <= {2{LINE_IDLE}};
            r_s_d  <= LINE_IDLE;
            r_os   <= '0;
            r_idx  <= '0;
            r_sh   <= '0;
            r_v7   <= 1'b0;
            r_v8   <= 1'b0;
            r_data <= '0;
            r_vld  <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], RS232_DCE_RXD};
            r_s_d  <= w_s;
            // In WAIT_IDLE os counts consecutive idle ticks instead.
            if (w_clr || w_ferr) begin
                r_os <= '0;
            end else if (w_tick) begin
                if (r_state == WAIT_IDLE && w_s != LINE_IDLE) begin
                    r_os <= '0;
                end else begin
                    r_os <= r_os + 4'd1;
                end
            end
            if (w_clr) begin
                r_idx <= '0;
            end
            if (w_tick && r_os == OS_V0) begin
                r_v7 <= w_s;
            end
            if (w_tick && r_os == OS_V1) begin
                r_v8 <= w_s;
            end
            if (r_state == DATA && w_mid) begin
                r_sh  <= {~w_vote, r_sh[7:1]};
                r_idx <= r_idx + 3'd1;
            end
            r_ferr <= w_ferr;
            r_ovr  <= w_dlv && r_vld && !rx.rx_rdy;
            if (w_dlv && (!r_vld || rx.rx_rdy)) begin
                r_data <= r_sh;
                r_vld  <= 1'b1;
            end else if (r_vld && rx.rx_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign rx.rx_data = r_data;
    assign rx.rx_vld  = r_vld;
    assign rx.rx_ferr = r_ferr;
    assign rx.rx_ovr  = r_ovr;

endmodule

// File: doc/rs232_rx.md
Name: rs232_rx

Overview:
- Serial receiver that consumes the line driven by the team's RS232 transmitter and produces parallel bytes.
- Line polarity matches that transmitter: idle 0, start bit 1, data bits inverted, stop bit 0.
- Uses 16x oversampling with 3-sample majority vote, and delivers bytes over a valid/ready handshake to a downstream consumer (FIFO or command parser).
- Flags framing errors and overruns.

Parameters:
- baud, 9600, line bit rate.
- mhz, 50, clock frequency in MHz.
- TICK_DIV (derived, not overridable), (mhz*1_000_000)/(baud*16), clocks per oversample tick; truncating division. The default is 325.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-low reset.
- RS232_DCE_RXD  in  1  asynchronous serial line.
- rx_data  out  8  received byte, LSB first on line, already de-inverted.
- rx_vld  out  1  rx_data valid; held until accepted.
- rx_rdy  in  1  consumer accepts when rx_vld && rx_rdy at posedge.
- rx_ferr  out  1  one-cycle pulse: framing error.
- rx_ovr  out  1  one-cycle pulse: byte lost to overrun.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; rx_data=0, rx_vld=0, rx_ferr=0, rx_ovr=0; tick and bit counters cleared; synchronizer flops loaded with 0 (idle).
- Reset mid-frame abandons the frame with no flags.
- Input path: 2-flop synchronizer. All decisions use the synchronized signal `s`.
- Tick generator: counts 0..TICK_DIV-1 and emits a one-cycle `tick` at the wrap. It is cleared on the start-edge detection cycle so that tick phases align to the frame.
- Oversample counter `os` runs 0..15 per bit. The bit value is the majority of `s` at os=7, 8, 9.
- States:
  - IDLE: on `s` rising from 0 to 1 (start edge), clear tick/os and go to START.
  - START: at os=9 evaluate the vote.
    - Vote=1: go to DATA with bit index 0.
    - Vote=0: false start; return to IDLE with no flags.
  - DATA: at os=9 shift `~vote` into the shift register (LSB first), i.e. received line level 1 gives data 0. After bit index 7, go to STOP.
  - STOP: at os=9 evaluate the vote.
    - Vote=0 (valid stop): deliver the byte, go to IDLE.
    - Vote=1: pulse rx_ferr, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `s`==0 for 16 consecutive ticks (break/stuck-line protection), then go to IDLE.
- Re-arm: IDLE is entered at the stop-bit midpoint, so a back-to-back start edge about half a bit later is caught.
- Delivery (cycle after the stop vote):
  - If rx_vld==0 or (rx_vld && rx_rdy) in that cycle: load rx_data and set rx_vld=1.
  - Otherwise (rx_vld high, rx_rdy low): keep the old rx_data/rx_vld unchanged, drop the new byte, pulse rx_ovr.
- rx_vld clears on the cycle after an accepting handshake unless a new byte loads in that same cycle, in which case it stays 1.
- rx_data is stable while rx_vld=1.
- Latency: rx_vld rises 1 clock after the stop-bit os=9 tick, plus 2 clocks of synchronizer delay relative to the raw line.
- rx_ferr and rx_ovr are never asserted in the same cycle. Each is exactly 1 clock wide.
- Widths: tick counter is $clog2(TICK_DIV) bits; os is 4 bits; bit index is 3 bits.
- Degenerate parameter: TICK_DIV must be ≥1. TICK_DIV==1 means tick is asserted every cycle.

Decomposition:
- Package rs232_pkg holds:
  - state enum: IDLE, START, DATA, STOP, WAIT_IDLE;
  - constant OVS=16;
  - vote sample points 7/8/9;
  - line-level constants LINE_IDLE=0, LINE_START=1, shared with the transmitter.
- One sub-module rs232_baud_tick (parameter DIV, inputs clock/reset/clr, output tick) is natural. The transmitter can later reuse it.

Test Plan (sim parameters mhz=1, baud=62500 → TICK_DIV=1, 16 clocks/bit):
1. Single byte: drive line for data 0xA5 (start 1, bits inverted LSB first, stop 0), rx_rdy=1 → one rx_vld pulse with rx_data=0xA5, no rx_ferr/rx_ovr.
2. Glitch: line high for 5 clocks then low → state returns to IDLE, no rx_vld, no flags; then a following 0x3C frame → rx_data=0x3C.
3. Back-to-back with backpressure: send 0x11 then 0x22 with rx_rdy=0 throughout → rx_vld=1 with rx_data=0x11 stays held, rx_ovr pulses once at the 0x22 stop; raise rx_rdy → rx_vld drops, no 0x22 delivered.
4. Framing error: send 0x55 with stop bit driven 1 and line held 1 for 40 more clocks → rx_ferr pulses once, no rx_vld; after line returns to 0 for ≥16 clocks, a 0x0F frame is received correctly.
5. Noise: single-clock inversion at os=8 of data bit 3 while sending 0xF0 → majority vote still yields rx_data=0xF0.
6. Reset mid-frame: assert reset during DATA bit 4 of 0x99 → all outputs 0; frame ignored; next 0x81 frame received as 0x81.
